// File: rtl/load_store_aligner_pkg.sv
// Shared load/store encodings and lane helpers, reused by the aligner,
// the endian stage and the core decoder.
package load_store_aligner_pkg;

  localparam logic [1:0] LDST_BYTE = 2'd0;
  localparam logic [1:0] LDST_HALF = 2'd1;
  localparam logic [1:0] LDST_WORD = 2'd2;

  typedef struct packed {
    logic        rw;
    logic [1:0]  order;
    logic [31:0] addr;
    logic [3:0]  mask;
    logic [31:0] data;
  } ldst_req_t;

  typedef struct packed {
    logic [1:0] order;
    logic [1:0] lane;
  } ldst_trk_t;

  function automatic logic [3:0] ldst_mask(input logic [1:0] order, input logic [1:0] lane);
    case (order)
      LDST_BYTE: ldst_mask = 4'b0001 << lane;
      LDST_HALF: ldst_mask = lane[1] ? 4'b1100 : 4'b0011;
      default:   ldst_mask = 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] ldst_place(input logic [1:0] order, input logic [1:0] lane,
                                             input logic [31:0] data);
    case (order)
      LDST_BYTE: ldst_place = {24'b0, data[7:0]} << {lane, 3'b000};
      LDST_HALF: ldst_place = lane[1] ? {data[15:0], 16'b0} : {16'b0, data[15:0]};
      default:   ldst_place = data;
    endcase
  endfunction

  // Reserved order 3 falls into the word case everywhere.
  function automatic logic ldst_misaligned(input logic [1:0] order, input logic [1:0] lane);
    case (order)
      LDST_BYTE: ldst_misaligned = 1'b0;
      LDST_HALF: ldst_misaligned = lane[0];
      default:   ldst_misaligned = |lane;
    endcase
  endfunction

  function automatic logic [31:0] ldst_extract(input logic [1:0] order, input logic [1:0] lane,
                                               input logic [31:0] word);
    logic [31:0] shifted;
    shifted = word >> {lane, 3'b000};
    case (order)
      LDST_BYTE: ldst_extract = {24'b0, shifted[7:0]};
      LDST_HALF: ldst_extract = lane[1] ? {16'b0, word[31:16]} : {16'b0, word[15:0]};
      default:   ldst_extract = word;
    endcase
  endfunction

endpackage

// File: rtl/load_store_aligner_fifo.sv
// Small synchronous FIFO used for both the request buffer and the load
// tracking queue; push is allowed when full if a pop happens the same cycle.
module ldst_fifo2 #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic             i_clock,
  input  logic             i_reset,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic [WIDTH-1:0] i_data,
  output logic [WIDTH-1:0] o_data,
  output logic             o_full,
  output logic             o_empty
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_rdPtr;
  logic [PW-1:0]    r_wrPtr;
  logic [CW-1:0]    r_count;
  logic             w_doPush;
  logic             w_doPop;

  assign o_full   = (r_count == CW'(DEPTH));
  assign o_empty  = (r_count == '0);
  assign o_data   = r_mem[r_rdPtr];
  assign w_doPop  = i_pop && !o_empty;
  assign w_doPush = i_push && (!o_full || w_doPop);

  // Storage is cleared on reset so the head reads as zero while empty.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_rdPtr <= '0;
      r_wrPtr <= '0;
      r_count <= '0;
    end else begin
      if (w_doPush) begin
        r_mem[r_wrPtr] <= i_data;
        r_wrPtr        <= (r_wrPtr == LAST) ? '0 : r_wrPtr + PW'(1);
      end
      if (w_doPop) r_rdPtr <= (r_rdPtr == LAST) ? '0 : r_rdPtr + PW'(1);
      r_count <= r_count + CW'(w_doPush) - CW'(w_doPop);
    end
  end

endmodule

// File: rtl/load_store_aligner.sv
// Aligns core load/store requests into word address, byte mask and lane data,
// buffers them toward memory and right-aligns returned load words.
module load_store_aligner
  import load_store_aligner_pkg::*;
#(
  parameter int FIFO_DEPTH = 2
) (
  input  logic        iCLOCK,
  input  logic        iRESET_SYNC,
  input  logic        iLDST_REQ,
  output logic        oLDST_BUSY,
  input  logic        iLDST_RW,
  input  logic [1:0]  iLDST_ORDER,
  input  logic [31:0] iLDST_ADDR,
  input  logic [31:0] iLDST_DATA,
  output logic        oMEM_REQ,
  input  logic        iMEM_BUSY,
  output logic        oMEM_RW,
  output logic [31:0] oMEM_ADDR,
  output logic [3:0]  oMEM_MASK,
  output logic [31:0] oMEM_DATA,
  input  logic        iMEM_VALID,
  input  logic [31:0] iMEM_DATA,
  output logic        oLDST_VALID,
  output logic [31:0] oLDST_DATA,
  output logic        oFAULT_MISALIGN,
  output logic [31:0] oFAULT_ADDR
);
  ldst_req_t   w_reqIn;
  ldst_req_t   w_reqHead;
  ldst_trk_t   w_trkIn;
  ldst_trk_t   w_trkHead;
  logic        w_reqFull, w_reqEmpty, w_trkFull, w_trkEmpty;
  logic        w_accept, w_misalign, w_reqPush, w_reqPop;
  logic        w_trkPush, w_trkPop, w_issueOk;
  logic        r_ldstValid;
  logic [31:0] r_ldstData;
  logic        r_fault;
  logic [31:0] r_faultAddr;

  assign w_accept   = iLDST_REQ && !w_reqFull;
  assign w_misalign = ldst_misaligned(iLDST_ORDER, iLDST_ADDR[1:0]);
  assign w_reqPush  = w_accept && !w_misalign;

  always_comb begin
    w_reqIn       = '0;
    w_reqIn.rw    = iLDST_RW;
    w_reqIn.order = iLDST_ORDER;
    w_reqIn.addr  = iLDST_ADDR;
    w_reqIn.mask  = ldst_mask(iLDST_ORDER, iLDST_ADDR[1:0]);
    w_reqIn.data  = iLDST_RW ? ldst_place(iLDST_ORDER, iLDST_ADDR[1:0], iLDST_DATA) : 32'h0;
  end

  // A load may only leave when a tracking slot is free or frees up this cycle.
  assign w_trkPop  = iMEM_VALID && !w_trkEmpty;
  assign w_issueOk = w_reqHead.rw || !w_trkFull || w_trkPop;
  assign oMEM_REQ  = !w_reqEmpty && w_issueOk;
  assign w_reqPop  = oMEM_REQ && !iMEM_BUSY;
  assign w_trkPush = w_reqPop && !w_reqHead.rw;

  always_comb begin
    w_trkIn       = '0;
    w_trkIn.order = w_reqHead.order;
    w_trkIn.lane  = w_reqHead.addr[1:0];
  end

  ldst_fifo2 #(.WIDTH($bits(ldst_req_t)), .DEPTH(FIFO_DEPTH)) u_reqFifo (
    .i_clock (iCLOCK),
    .i_reset (iRESET_SYNC),
    .i_push  (w_reqPush),
    .i_pop   (w_reqPop),
    .i_data  (w_reqIn),
    .o_data  (w_reqHead),
    .o_full  (w_reqFull),
    .o_empty (w_reqEmpty)
  );

  ldst_fifo2 #(.WIDTH($bits(ldst_trk_t)), .DEPTH(FIFO_DEPTH)) u_trkFifo (
    .i_clock (iCLOCK),
    .i_reset (iRESET_SYNC),
    .i_push  (w_trkPush),
    .i_pop   (w_trkPop),
    .i_data  (w_trkIn),
    .o_data  (w_trkHead),
    .o_full  (w_trkFull),
    .o_empty (w_trkEmpty)
  );

  assign oLDST_BUSY = w_reqFull;
  assign oMEM_RW    = w_reqHead.rw;
  assign oMEM_ADDR  = {w_reqHead.addr[31:2], 2'b00};
  assign oMEM_MASK  = w_reqHead.mask;
  assign oMEM_DATA  = w_reqHead.data;

  // Load results and misalignment faults are both one-cycle registered pulses.
  always_ff @(posedge iCLOCK) begin
    if (iRESET_SYNC) begin
      r_ldstValid <= 1'b0;
      r_ldstData  <= 32'h0;
      r_fault     <= 1'b0;
      r_faultAddr <= 32'h0;
    end else begin
      r_ldstValid <= w_trkPop;
      if (w_trkPop) r_ldstData <= ldst_extract(w_trkHead.order, w_trkHead.lane, iMEM_DATA);
      r_fault <= w_accept && w_misalign;
      if (w_accept && w_misalign) r_faultAddr <= iLDST_ADDR;
    end
  end

  assign oLDST_VALID     = r_ldstValid;
  assign oLDST_DATA      = r_ldstData;
  assign oFAULT_MISALIGN = r_fault;
  assign oFAULT_ADDR     = r_faultAddr;

endmodule

// File: tb/tb_load_store_aligner.sv
// Scoreboard bench for load_store_aligner: directed scenarios followed by
// randomized traffic against a byte-arithmetic reference model.
module tb_load_store_aligner;

  logic        iCLOCK = 1'b0;
  logic        iRESET_SYNC;
  logic        iLDST_REQ;
  logic        oLDST_BUSY;
  logic        iLDST_RW;
  logic [1:0]  iLDST_ORDER;
  logic [31:0] iLDST_ADDR;
  logic [31:0] iLDST_DATA;
  logic        oMEM_REQ;
  logic        iMEM_BUSY;
  logic        oMEM_RW;
  logic [31:0] oMEM_ADDR;
  logic [3:0]  oMEM_MASK;
  logic [31:0] oMEM_DATA;
  logic        iMEM_VALID;
  logic [31:0] iMEM_DATA;
  logic        oLDST_VALID;
  logic [31:0] oLDST_DATA;
  logic        oFAULT_MISALIGN;
  logic [31:0] oFAULT_ADDR;

  load_store_aligner #(.FIFO_DEPTH(2)) dut (
    .iCLOCK          (iCLOCK),
    .iRESET_SYNC     (iRESET_SYNC),
    .iLDST_REQ       (iLDST_REQ),
    .oLDST_BUSY      (oLDST_BUSY),
    .iLDST_RW        (iLDST_RW),
    .iLDST_ORDER     (iLDST_ORDER),
    .iLDST_ADDR      (iLDST_ADDR),
    .iLDST_DATA      (iLDST_DATA),
    .oMEM_REQ        (oMEM_REQ),
    .iMEM_BUSY       (iMEM_BUSY),
    .oMEM_RW         (oMEM_RW),
    .oMEM_ADDR       (oMEM_ADDR),
    .oMEM_MASK       (oMEM_MASK),
    .oMEM_DATA       (oMEM_DATA),
    .iMEM_VALID      (iMEM_VALID),
    .iMEM_DATA       (iMEM_DATA),
    .oLDST_VALID     (oLDST_VALID),
    .oLDST_DATA      (oLDST_DATA),
    .oFAULT_MISALIGN (oFAULT_MISALIGN),
    .oFAULT_ADDR     (oFAULT_ADDR)
  );

  always #5 iCLOCK = ~iCLOCK;

  typedef struct {
    bit        rw;
    bit [1:0]  ord;
    bit [1:0]  lane;
    bit [31:0] addr;
    bit [3:0]  mask;
    bit [31:0] data;
  } memExp_t;

  typedef struct {
    bit [31:0] value;
    int        due;
  } timed_t;

  typedef struct {
    bit [1:0] ord;
    bit [1:0] lane;
  } pend_t;

  memExp_t memQ[$];
  timed_t  ldQ[$];
  timed_t  faultQ[$];
  pend_t   pendQ[$];
  int      testsRun = 0;
  int      testsFailed = 0;
  int      cyc = 0;
  bit      driverDone = 1'b0;

  always @(posedge iCLOCK) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  task automatic checkBit(input string name, input logic actual, input logic expected);
    checkOutput(name, {31'b0, actual}, {31'b0, expected});
  endtask

  // Reference model: sizes in bytes, lanes and masks by plain arithmetic.
  function automatic int sizeOf(input bit [1:0] ord);
    return (ord == 2'd0) ? 1 : (ord == 2'd1) ? 2 : 4;
  endfunction

  function automatic longint unsigned widthMask(input bit [1:0] ord);
    return (64'd1 << (8 * sizeOf(ord))) - 64'd1;
  endfunction

  function automatic void pushExpected(input bit rw, input bit [1:0] ord, input bit [31:0] a, input bit [31:0] d);
    int lane;
    memExp_t e;
    lane = int'(a % 4);
    if ((a % sizeOf(ord)) != 0) begin
      faultQ.push_back('{value: a, due: cyc + 1});
    end else begin
      e.rw   = rw;
      e.ord  = ord;
      e.lane = 2'(lane);
      e.addr = a - (a % 4);
      e.mask = 4'(((1 << sizeOf(ord)) - 1) << lane);
      e.data = rw ? 32'(({32'b0, d} & widthMask(ord)) << (8 * lane)) : 32'h0;
      memQ.push_back(e);
    end
  endfunction

  function automatic bit [31:0] loadResult(input bit [1:0] ord, input bit [1:0] lane, input bit [31:0] w);
    return 32'(({32'b0, w} >> (8 * int'(lane))) & widthMask(ord));
  endfunction

  // Monitor: compares every presented output against the scoreboard queues.
  always @(negedge iCLOCK) begin : monitor
    int      pendBefore;
    pend_t   p;
    memExp_t e;
    timed_t  t;
    if (oLDST_VALID || (ldQ.size() > 0 && ldQ[0].due == cyc)) begin
      if (ldQ.size() == 0) checkBit("ldst_valid_spurious", oLDST_VALID, 1'b0);
      else begin
        t = ldQ.pop_front();
        checkBit("ldst_valid", oLDST_VALID, 1'b1);
        checkOutput("ldst_cycle", cyc, t.due);
        checkOutput("ldst_data", oLDST_DATA, t.value);
      end
    end
    if (oFAULT_MISALIGN || (faultQ.size() > 0 && faultQ[0].due == cyc)) begin
      if (faultQ.size() == 0) checkBit("fault_spurious", oFAULT_MISALIGN, 1'b0);
      else begin
        t = faultQ.pop_front();
        checkBit("fault_pulse", oFAULT_MISALIGN, 1'b1);
        checkOutput("fault_cycle", cyc, t.due);
        checkOutput("fault_addr", oFAULT_ADDR, t.value);
      end
    end
    pendBefore = pendQ.size();
    if (iMEM_VALID && pendBefore > 0) begin
      p = pendQ.pop_front();
      ldQ.push_back('{value: loadResult(p.ord, p.lane, iMEM_DATA), due: cyc + 1});
    end
    if (oMEM_REQ) begin
      if (memQ.size() == 0) checkBit("mem_req_spurious", oMEM_REQ, 1'b0);
      else begin
        e = memQ[0];
        checkBit("mem_rw", oMEM_RW, e.rw);
        checkOutput("mem_addr", oMEM_ADDR, e.addr);
        checkOutput("mem_mask", {28'b0, oMEM_MASK}, {28'b0, e.mask});
        checkOutput("mem_data", oMEM_DATA, e.data);
        if (!iMEM_BUSY) begin
          e = memQ.pop_front();
          if (!e.rw) begin
            checkBit("load_gate_room", (pendBefore < 2) || iMEM_VALID, 1'b1);
            pendQ.push_back('{ord: e.ord, lane: e.lane});
          end
        end
      end
    end
    if (iRESET_SYNC) begin
      memQ.delete();
      ldQ.delete();
      faultQ.delete();
      pendQ.delete();
    end
  end

  task automatic stepCycle();
    @(posedge iCLOCK);
    #1;
  endtask

  task automatic applyStimulus(input bit rw, input bit [1:0] ord, input bit [31:0] a, input bit [31:0] d);
    int waited;
    waited = 0;
    iLDST_REQ   = 1'b1;
    iLDST_RW    = rw;
    iLDST_ORDER = ord;
    iLDST_ADDR  = a;
    iLDST_DATA  = d;
    forever begin
      @(negedge iCLOCK);
      if (!oLDST_BUSY) begin
        pushExpected(rw, ord, a, d);
        break;
      end
      waited++;
      if (waited > 200) begin
        checkBit("accept_timeout", oLDST_BUSY, 1'b0);
        break;
      end
      @(posedge iCLOCK);
      #1;
    end
    stepCycle();
    iLDST_REQ = 1'b0;
  endtask

  task automatic checkAllZero(input string tag);
    checkBit({tag, "_busy"}, oLDST_BUSY, 1'b0);
    checkBit({tag, "_memreq"}, oMEM_REQ, 1'b0);
    checkBit({tag, "_memrw"}, oMEM_RW, 1'b0);
    checkOutput({tag, "_memaddr"}, oMEM_ADDR, 32'h0);
    checkOutput({tag, "_memmask"}, {28'b0, oMEM_MASK}, 32'h0);
    checkOutput({tag, "_memdata"}, oMEM_DATA, 32'h0);
    checkBit({tag, "_ldvalid"}, oLDST_VALID, 1'b0);
    checkOutput({tag, "_lddata"}, oLDST_DATA, 32'h0);
    checkBit({tag, "_fault"}, oFAULT_MISALIGN, 1'b0);
    checkOutput({tag, "_faultaddr"}, oFAULT_ADDR, 32'h0);
  endtask

  initial begin : watchdog
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : main
    logic [31:0] a;
    iRESET_SYNC = 1'b1;
    iLDST_REQ   = 1'b0;
    iLDST_RW    = 1'b0;
    iLDST_ORDER = 2'd0;
    iLDST_ADDR  = 32'h0;
    iLDST_DATA  = 32'h0;
    iMEM_BUSY   = 1'b0;
    iMEM_VALID  = 1'b0;
    iMEM_DATA   = 32'h0;
    repeat (3) @(posedge iCLOCK);
    #1 iRESET_SYNC = 1'b0;
    @(negedge iCLOCK);
    checkAllZero("reset");
    stepCycle();

    // Byte store to the top lane
    applyStimulus(1'b1, 2'd0, 32'h0000_1003, 32'h0000_00AB);
    @(negedge iCLOCK);
    checkBit("t1_req", oMEM_REQ, 1'b1);
    checkOutput("t1_addr", oMEM_ADDR, 32'h0000_1000);
    checkOutput("t1_mask", {28'b0, oMEM_MASK}, 32'h8);
    checkOutput("t1_data", oMEM_DATA, 32'hAB00_0000);
    stepCycle();

    // Upper half load and its return
    applyStimulus(1'b0, 2'd1, 32'h0000_2002, 32'hFFFF_FFFF);
    @(negedge iCLOCK);
    checkOutput("t2_mask", {28'b0, oMEM_MASK}, 32'hC);
    checkOutput("t2_data_zero", oMEM_DATA, 32'h0);
    stepCycle();
    iMEM_VALID = 1'b1;
    iMEM_DATA  = 32'h1234_5678;
    stepCycle();
    iMEM_VALID = 1'b0;
    @(negedge iCLOCK);
    checkBit("t2_valid", oLDST_VALID, 1'b1);
    checkOutput("t2_result", oLDST_DATA, 32'h0000_1234);
    stepCycle();

    // Misaligned word never reaches memory
    applyStimulus(1'b0, 2'd2, 32'h0000_3001, 32'h0);
    @(negedge iCLOCK);
    checkBit("t3_fault", oFAULT_MISALIGN, 1'b1);
    checkOutput("t3_faultaddr", oFAULT_ADDR, 32'h0000_3001);
    checkBit("t3_noreq", oMEM_REQ, 1'b0);
    stepCycle();
    @(negedge iCLOCK);
    checkBit("t3_pulse_end", oFAULT_MISALIGN, 1'b0);
    checkBit("t3_noreq_late", oMEM_REQ, 1'b0);
    stepCycle();

    // Backpressure: two stores fill the buffer, third is held
    iMEM_BUSY = 1'b1;
    applyStimulus(1'b1, 2'd2, 32'h0000_4000, 32'h1111_1111);
    applyStimulus(1'b1, 2'd2, 32'h0000_4004, 32'h2222_2222);
    iLDST_REQ   = 1'b1;
    iLDST_RW    = 1'b1;
    iLDST_ORDER = 2'd2;
    iLDST_ADDR  = 32'h0000_4008;
    iLDST_DATA  = 32'h3333_3333;
    for (int k = 0; k < 3; k++) begin
      @(negedge iCLOCK);
      checkBit("t4_busy", oLDST_BUSY, 1'b1);
      checkOutput("t4_hold_addr", oMEM_ADDR, 32'h0000_4000);
      stepCycle();
    end
    iMEM_BUSY = 1'b0;
    @(negedge iCLOCK);
    checkBit("t4_busy_no_bypass", oLDST_BUSY, 1'b1);
    stepCycle();
    @(negedge iCLOCK);
    checkBit("t4_busy_clear", oLDST_BUSY, 1'b0);
    pushExpected(1'b1, 2'd2, 32'h0000_4008, 32'h3333_3333);
    stepCycle();
    iLDST_REQ = 1'b0;
    repeat (4) stepCycle();

    // Load gating: third load waits for a return
    applyStimulus(1'b0, 2'd0, 32'h0000_5001, 32'h0);
    applyStimulus(1'b0, 2'd1, 32'h0000_5002, 32'h0);
    applyStimulus(1'b0, 2'd2, 32'h0000_5004, 32'h0);
    for (int k = 0; k < 3; k++) begin
      @(negedge iCLOCK);
      checkBit("t5_gated", oMEM_REQ, 1'b0);
      stepCycle();
    end
    iMEM_VALID = 1'b1;
    iMEM_DATA  = 32'hA1B2_C3D4;
    @(negedge iCLOCK);
    checkBit("t5_issue_on_return", oMEM_REQ, 1'b1);
    stepCycle();
    iMEM_DATA = 32'h8765_4321;
    @(negedge iCLOCK);
    checkOutput("t5_byte_result", oLDST_DATA, 32'h0000_00C3);
    stepCycle();
    iMEM_DATA = 32'hCAFE_F00D;
    @(negedge iCLOCK);
    checkOutput("t5_half_result", oLDST_DATA, 32'h0000_8765);
    stepCycle();
    iMEM_VALID = 1'b0;
    @(negedge iCLOCK);
    checkOutput("t5_word_result", oLDST_DATA, 32'hCAFE_F00D);
    stepCycle();

    // Reset with two loads outstanding, then a stale return
    applyStimulus(1'b0, 2'd2, 32'h0000_6000, 32'h0);
    applyStimulus(1'b0, 2'd2, 32'h0000_6004, 32'h0);
    repeat (3) stepCycle();
    iRESET_SYNC = 1'b1;
    repeat (2) stepCycle();
    iRESET_SYNC = 1'b0;
    iMEM_VALID  = 1'b1;
    iMEM_DATA   = 32'hFFFF_FFFF;
    stepCycle();
    iMEM_VALID = 1'b0;
    @(negedge iCLOCK);
    checkAllZero("t6");
    stepCycle();

    // Randomized traffic with random memory stalls and returns
    fork
      begin
        for (int i = 0; i < 200; i++) begin
          a = $urandom;
          if ($urandom_range(0, 1) == 0) a[1:0] = 2'b00;
          if ($urandom_range(0, 3) == 0) begin
            iLDST_REQ = 1'b0;
            stepCycle();
          end
          applyStimulus(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), a, $urandom);
        end
        iLDST_REQ  = 1'b0;
        driverDone = 1'b1;
      end
      begin
        int guard;
        guard = 0;
        while ((!driverDone || memQ.size() > 0 || pendQ.size() > 0) && guard < 20000) begin
          iMEM_BUSY  = ($urandom_range(0, 3) == 0);
          iMEM_VALID = ($urandom_range(0, 2) == 0);
          iMEM_DATA  = $urandom;
          stepCycle();
          guard++;
        end
        iMEM_BUSY  = 1'b0;
        iMEM_VALID = 1'b0;
        checkBit("random_drain", guard < 20000, 1'b1);
      end
    join
    repeat (5) stepCycle();

    checkOutput("sb_mem_left", memQ.size(), 32'd0);
    checkOutput("sb_load_left", ldQ.size(), 32'd0);
    checkOutput("sb_fault_left", faultQ.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
